// File: rtl/rb_wb_arb_pkg.sv
// Shared definitions for the register-bank writeback path: default widths and arbiter states.
package rb_wb_arb_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arbState_t;
endpackage

// File: rtl/rb_wb_arb_rr_arb2.sv
// Two-requester round-robin grant: ptr=0 lets the ALU win a tie, ptr=1 lets memory win.
module rr_arb2 (
   input  logic reqA,
   input  logic reqM,
   input  logic ptr,
   output logic gntA,
   output logic gntM
);
   always_comb begin
      gntA = reqA & (~reqM | ~ptr);
      gntM = reqM & (~reqA | ptr);
   end
endmodule

// File: rtl/rb_wb_arb.sv
// Writeback arbiter for the register bank: zero-sweeps the bank after reset or on request,
// then merges ALU and load writebacks round-robin with one cycle of latency.
module rb_wb_arb
   import rb_wb_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              m_valid,
   input  logic [ADDR_W-1:0] m_reg,
   input  logic [DATA_W-1:0] m_data,
   output logic              m_ready,
   output logic              regWrite,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              busy,
   output logic              clear_done
);
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   arbState_t         stateReg, stateNext;
   logic [ADDR_W-1:0] clrIdxReg, clrIdxNext;
   logic              rrPtrReg, rrPtrNext;
   logic              wrValidReg, wrValidNext;
   logic [ADDR_W-1:0] wrRegReg, wrRegNext;
   logic [DATA_W-1:0] wrDataReg, wrDataNext;

   logic              inRun, gntA, gntM;
   logic [ADDR_W-1:0] hsReg;
   logic [DATA_W-1:0] hsData;

   assign inRun = (stateReg == RUN) && !rst;

   rr_arb2 u_rrArb (
      .reqA (a_valid & inRun),
      .reqM (m_valid & inRun),
      .ptr  (rrPtrReg),
      .gntA (gntA),
      .gntM (gntM)
   );

   assign a_ready = gntA;
   assign m_ready = gntM;
   assign hsReg   = gntM ? m_reg : a_reg;
   assign hsData  = gntM ? m_data : a_data;

   // wrRegReg/wrDataReg always hold the most recent bank write, so they double as the hold value.
   always_comb begin
      stateNext   = stateReg;
      clrIdxNext  = clrIdxReg;
      rrPtrNext   = rrPtrReg;
      wrValidNext = 1'b0;
      wrRegNext   = wrRegReg;
      wrDataNext  = wrDataReg;
      case (stateReg)
         CLEAR: begin
            // A write accepted alongside clear_req goes out first; the sweep waits one cycle.
            if (!wrValidReg) begin
               wrRegNext  = clrIdxReg;
               wrDataNext = '0;
               if (clrIdxReg == LAST_IDX) begin
                  stateNext  = RUN;
                  clrIdxNext = '0;
               end else begin
                  clrIdxNext = clrIdxReg + ADDR_W'(1);
               end
            end
         end
         RUN: begin
            if (gntA || gntM) begin
               rrPtrNext = gntA;
               if (hsReg != '0) begin
                  wrValidNext = 1'b1;
                  wrRegNext   = hsReg;
                  wrDataNext  = hsData;
               end
            end
            if (clear_req) begin
               stateNext  = CLEAR;
               clrIdxNext = '0;
            end
         end
         default: stateNext = CLEAR;
      endcase
   end

   always_comb begin
      regWrite   = 1'b0;
      writeReg   = '0;
      writeData  = '0;
      clear_done = 1'b0;
      busy       = 1'b1;
      if (!rst) begin
         busy = (stateReg == CLEAR);
         if ((stateReg == CLEAR) && !wrValidReg) begin
            regWrite   = 1'b1;
            writeReg   = clrIdxReg;
            writeData  = '0;
            clear_done = (clrIdxReg == LAST_IDX);
         end else begin
            regWrite  = wrValidReg;
            writeReg  = wrRegReg;
            writeData = wrDataReg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg   <= CLEAR;
         clrIdxReg  <= '0;
         rrPtrReg   <= 1'b0;
         wrValidReg <= 1'b0;
         wrRegReg   <= '0;
         wrDataReg  <= '0;
      end else begin
         stateReg   <= stateNext;
         clrIdxReg  <= clrIdxNext;
         rrPtrReg   <= rrPtrNext;
         wrValidReg <= wrValidNext;
         wrRegReg   <= wrRegNext;
         wrDataReg  <= wrDataNext;
      end
   end
endmodule

// File: tb/tb_rb_wb_arb.sv
// Randomised bench for rb_wb_arb; expected outputs come from a queue of scheduled bank writes.
module tb_rb_wb_arb;
   logic        clk;
   logic        rst;
   logic        clear_req;
   logic        a_valid, m_valid;
   logic [4:0]  a_reg, m_reg;
   logic [31:0] a_data, m_data;
   logic        a_ready, m_ready;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        busy, clear_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      bit        we;
      bit [4:0]  rg;
      bit [31:0] dat;
      bit        done;
      bit        sweep;
   } exp_t;

   exp_t      expQ[$];
   bit [4:0]  lastReg;
   bit [31:0] lastData;
   bit        favourM;

   rb_wb_arb #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_req  (clear_req),
      .a_valid    (a_valid),
      .a_reg      (a_reg),
      .a_data     (a_data),
      .a_ready    (a_ready),
      .m_valid    (m_valid),
      .m_reg      (m_reg),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .regWrite   (regWrite),
      .writeReg   (writeReg),
      .writeData  (writeData),
      .busy       (busy),
      .clear_done (clear_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic scheduleSweep();
      for (int i = 0; i < 32; i++) begin
         exp_t e;
         e.we    = 1'b1;
         e.rg    = 5'(i);
         e.dat   = '0;
         e.done  = (i == 31);
         e.sweep = 1'b1;
         expQ.push_back(e);
      end
   endtask

   // Reference: a sweep is 32 queued zero-writes; a handshake queues its write for the next cycle.
   always @(negedge clk) begin
      exp_t cur;
      bit   sweeping, expA, expM;
      cyc++;
      if (rst) begin
         chk("rst_regWrite", regWrite, 0);
         chk("rst_writeReg", writeReg, 0);
         chk("rst_writeData", writeData, 0);
         chk("rst_a_ready", a_ready, 0);
         chk("rst_m_ready", m_ready, 0);
         chk("rst_clear_done", clear_done, 0);
         chk("rst_busy", busy, 1);
         expQ.delete();
         scheduleSweep();
         lastReg  = '0;
         lastData = '0;
         favourM  = 1'b0;
      end else begin
         sweeping = 1'b0;
         foreach (expQ[i]) if (expQ[i].sweep) sweeping = 1'b1;
         if (expQ.size() > 0) cur = expQ[0];
         else cur = '{we: 1'b0, rg: lastReg, dat: lastData, done: 1'b0, sweep: 1'b0};
         expA = !sweeping && a_valid && (!m_valid || !favourM);
         expM = !sweeping && m_valid && (!a_valid || favourM);
         chk("regWrite", regWrite, cur.we);
         chk("writeReg", writeReg, cur.rg);
         chk("writeData", writeData, cur.dat);
         chk("clear_done", clear_done, cur.done);
         chk("busy", busy, sweeping);
         chk("a_ready", a_ready, expA);
         chk("m_ready", m_ready, expM);
         if (expQ.size() > 0) void'(expQ.pop_front());
         if (cur.we) begin
            lastReg  = cur.rg;
            lastData = cur.dat;
         end
         if (expA || expM) begin
            exp_t w;
            w.we    = 1'b1;
            w.rg    = expA ? a_reg : m_reg;
            w.dat   = expA ? a_data : m_data;
            w.done  = 1'b0;
            w.sweep = 1'b0;
            $display("txn cyc=%0d src=%s reg=%0d data=%0h", cyc, expA ? "A" : "M", w.rg, w.dat);
            if (w.rg != 0) expQ.push_back(w);
            favourM = expA;
         end
         if (clear_req && !sweeping) scheduleSweep();
      end
   end

   task automatic step(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                       input bit mv, input bit [4:0] mr, input bit [31:0] md,
                       input bit cr, input bit r);
      a_valid   = av;
      a_reg     = ar;
      a_data    = ad;
      m_valid   = mv;
      m_reg     = mr;
      m_data    = md;
      clear_req = cr;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; clear_req = 1'b0;
      a_valid = 1'b0; a_reg = '0; a_data = '0;
      m_valid = 1'b0; m_reg = '0; m_data = '0;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
      // Sweep after reset, with a clear_req landing on sweep index 10 (ignored).
      idle(10);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      idle(25);
      step(1, 16, 50, 0, 0, 0, 0, 0);
      idle(2);
      for (int i = 0; i < 4; i++) step(1, 3, 32'h100 + i, 1, 7, 32'h200 + i, 0, 0);
      idle(2);
      step(0, 0, 0, 1, 0, 50, 0, 0);
      idle(2);
      // clear_req with a concurrent ALU handshake, then reset at sweep index 20.
      step(1, 5, 32'h77, 0, 0, 0, 1, 0);
      idle(21);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(40);
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 63) == 0, $urandom_range(0, 299) == 0);
      end
      idle(40);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
